line_refill_responder: RTL and testbench
========================================

# line_refill_responder

Memory-side responder for the direct-mapped cache's line-fill interface. It accepts one miss request, carrying the line address, over a valid/ready handshake. After a fixed access latency it returns the full line as a burst of `LINE_WORDS` beats over a valid/ready response channel. Word content follows the cache model's fill rule: word `i` of a line equals line base address + `i`. It also keeps request and beat counters so hit/miss statistics can be cross-checked against memory traffic.

## Interface
Parameters:
- `ADDR_W`, 32, address and data width (data = address pattern).
- `LINE_WORDS`, 16, words per line; power of two, ≥2.
- `LATENCY`, 4, idle cycles between request acceptance and first response beat; 0 allowed.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  miss request present.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  ADDR_W  any address within the missing line.
- `rsp_valid`  out  1  response beat present.
- `rsp_ready`  in  1  cache accepts beat.
- `rsp_data`  out  ADDR_W  line base + beat index.
- `rsp_beat`  out  log2(LINE_WORDS)  index of current beat.
- `rsp_last`  out  1  high on final beat (`rsp_beat == LINE_WORDS-1`).
- `busy`  out  1  high in WAIT or BURST.
- `req_count`  out  32  accepted requests.
- `beat_count`  out  32  accepted response beats.

## Operation
- Three states:
  - IDLE: `req_ready`=1.
  - WAIT: latency countdown.
  - BURST: `rsp_valid`=1.
- Request handshake is `req_valid && req_ready`, and is only possible in IDLE.
  - On the handshake, latch base = `req_addr` with the low log2(`LINE_WORDS`) bits cleared.
  - Clear the beat index and increment `req_count`.
  - Next state is WAIT if `LATENCY>0`, else BURST.
- WAIT: a counter loads `LATENCY-1` on acceptance and decrements each cycle. At 0, go to BURST.
- BURST:
  - `rsp_data` = base + beat index, modulo 2^ADDR_W.
  - A beat handshake (`rsp_valid && rsp_ready`) increments the beat index and `beat_count`.
  - Handshake on the `rsp_last` beat returns the FSM to IDLE.
- Backpressure: while `rsp_valid && !rsp_ready`, `rsp_data`, `rsp_beat` and `rsp_last` hold stable. Beats are never skipped or repeated.
- `req_valid` during WAIT or BURST is ignored (`req_ready`=0). The requester holds it until accepted.
- Counters wrap at 2^32 without saturation.
- Reset (`rst_n` low at a clock edge, including mid-WAIT or mid-BURST):
  - State goes to IDLE; in-flight burst dropped.
  - `req_ready` then reads 1; all other outputs are 0 (`rsp_valid`, `rsp_data`, `rsp_beat`, `rsp_last`, `busy`, both counters).
- Outside BURST, `rsp_data`, `rsp_beat` and `rsp_last` read 0.

## Timing
- Acceptance at edge E: `busy`=1 and `req_ready`=0 from E onward.
- First `rsp_valid` appears after edge E+`LATENCY`, i.e. `LATENCY` full WAIT cycles.
  - With `LATENCY`=0, `rsp_valid` is high in the cycle right after acceptance.
- With `rsp_ready` held high, beats stream one per cycle. Occupancy = `LATENCY` + `LINE_WORDS` cycles after the accept cycle.
- `req_ready` returns to 1 in the cycle after the last-beat handshake. No same-cycle turnaround, so the minimum request spacing is `LATENCY` + `LINE_WORDS` + 1 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from `req_valid`/`rsp_ready` to any output.

## Structure
- Shared package `refill_pkg` holds:
  - state enum {IDLE, WAIT, BURST};
  - `OFFSET_W` = log2(`LINE_WORDS`) helper;
  - default `LINE_WORDS`/`LATENCY` constants shared with the cache.
- Single flat module; no sub-module warranted. The latency and beat counters are small enough to inline.

## Test plan
- Basic fill, `LATENCY`=4, `rsp_ready`=1, `req_addr`=0x0000_1237:
  - first beat 5 cycles after accept (0x0000_1230, beat 0);
  - 16 consecutive beats through 0x0000_123F with `rsp_last` on beat 15;
  - `req_ready` high the next cycle; `req_count`=1, `beat_count`=16.
- Backpressure: deassert `rsp_ready` for 3 cycles at beat 7 of line 0x0000_ABC0. `rsp_data` holds 0x0000_ABC7 and `rsp_beat`=7 throughout; the burst completes with exactly 16 accepted beats.
- `LATENCY`=0, `req_addr`=0xFFFF_FFF5: beat 0 = 0xFFFF_FFF0 in the cycle after accept; final beat = 0xFFFF_FFFF with no wrap error.
- Request while busy: hold `req_valid` with a second address 0x0000_2000 during a burst. It is not accepted until `req_ready` returns; then serviced normally; `req_count`=2.
- Reset mid-burst: drive `rst_n` low at beat 9.
  - Next cycle: `rsp_valid`=0, `busy`=0, `req_ready`=1, counters 0.
  - A following request at 0x0000_0040 returns the full 0x40..0x4F line.
- Back-to-back stream: 20 requests with `rsp_ready` randomly toggled. `beat_count` = 320 and `req_count` = 20 at the end; every beat matches base+index.

Source files
------------

// File: rtl/refill_pkg.sv
// Shared definitions for the line-fill responder and the cache side.
// State encoding, line geometry helper and default timing constants.
package refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int DEF_LINE_WORDS = 16;
    localparam int DEF_LATENCY    = 4;

    function automatic int offset_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/line_refill_responder.sv
// Memory-side responder: accepts one miss, waits a fixed latency, then
// bursts the whole line back, word i = line base + i.
module line_refill_responder
    import refill_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ADDR_W-1:0]             rsp_data,
    output logic [offset_w(LINE_WORDS)-1:0] rsp_beat,
    output logic                          rsp_last,
    output logic                          busy,
    output logic [31:0]                   req_count,
    output logic [31:0]                   beat_count
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LAT_W-1:0] LAT_LOAD =
        (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
    localparam state_t ACC_STATE = (LATENCY > 0) ? WAIT : BURST;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   base;
    logic [OFFSET_W-1:0] beat;
    logic [LAT_W-1:0]    lat_cnt;
    logic [31:0]         reqc;
    logic [31:0]         beatc;
    logic                req_fire;
    logic                rsp_fire;
    logic                at_last;

    assign at_last  = (beat == {OFFSET_W{1'b1}});
    assign req_fire = req_valid && (state == IDLE);
    assign rsp_fire = rsp_ready && (state == BURST);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_valid) state_n = ACC_STATE;
            WAIT:    if (lat_cnt == '0) state_n = BURST;
            BURST:   if (rsp_ready && at_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            base    <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            reqc    <= '0;
            beatc   <= '0;
        end else begin
            state <= state_n;
            if (req_fire) begin
                base    <= req_addr & BASE_MASK;
                beat    <= '0;
                lat_cnt <= LAT_LOAD;
                reqc    <= reqc + 32'd1;
            end
            if (state == WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            // Index wraps to 0 after the last beat, ready for the next line.
            if (rsp_fire) begin
                beat  <= beat + 1'b1;
                beatc <= beatc + 32'd1;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == BURST);
    assign rsp_data   = rsp_valid ? base + ADDR_W'(beat) : '0;
    assign rsp_beat   = rsp_valid ? beat : '0;
    assign rsp_last   = rsp_valid && at_last;
    assign req_count  = reqc;
    assign beat_count = beatc;

endmodule

// File: tb/tb_line_refill_responder.sv
// Bench for line_refill_responder: LATENCY=4 and LATENCY=0 instances
// driven by directed and random fills against a line-level model.
module tb_line_refill_responder;

    logic        clk;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_data   [2];
    logic [3:0]  rsp_beat   [2];
    logic        rsp_last   [2];
    logic        busy       [2];
    logic [31:0] req_count  [2];
    logic [31:0] beat_count [2];

    int unsigned mreq  [2];
    int unsigned mbeat [2];
    int          passed;
    int          failed;
    int          total;

    line_refill_responder #(.ADDR_W(32), .LINE_WORDS(16), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_beat(rsp_beat[0]),
        .rsp_last(rsp_last[0]), .busy(busy[0]),
        .req_count(req_count[0]), .beat_count(beat_count[0])
    );

    line_refill_responder #(.ADDR_W(32), .LINE_WORDS(16), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_beat(rsp_beat[1]),
        .rsp_last(rsp_last[1]), .busy(busy[1]),
        .req_count(req_count[1]), .beat_count(beat_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready[d]), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data[d]), 64'd0);
        chk({tag, "_rsp_beat"}, 64'(rsp_beat[d]), 64'd0);
        chk({tag, "_rsp_last"}, 64'(rsp_last[d]), 64'd0);
        chk({tag, "_busy"}, 64'(busy[d]), 64'd0);
        chk({tag, "_req_count"}, 64'(req_count[d]), 64'(mreq[d]));
        chk({tag, "_beat_count"}, 64'(beat_count[d]), 64'(mbeat[d]));
    endtask

    task automatic pulse_reset(input int d);
        @(negedge clk);
        rst_n[d]     = 1'b0;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        rst_n[d] = 1'b1;
        mreq[d]  = 0;
        mbeat[d] = 0;
    endtask

    // mode 0: always ready, 1: 3-cycle stall at beat 7, 2: random stalls
    task automatic run_line(input int d, input logic [31:0] addr,
                            input int mode, input int rst_beat,
                            input bit hold, input logic [31:0] nxt);
        int          n;
        int          stalls;
        int          lat;
        logic [31:0] base;
        lat  = (d == 0) ? 4 : 0;
        base = addr & ~32'hF;
        if (!req_valid[d]) begin
            @(negedge clk);
            req_valid[d] = 1'b1;
        end
        req_addr[d] = addr;
        n = 0;
        while (!req_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait_bound", 64'(n < 200), 64'd1);
        @(negedge clk);
        mreq[d]++;
        if (hold) req_addr[d] = nxt;
        else req_valid[d] = 1'b0;
        chk("accept_busy", 64'(busy[d]), 64'd1);
        chk("accept_req_ready", 64'(req_ready[d]), 64'd0);
        n = 0;
        while (!rsp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        for (int i = 0; i < 16; i++) begin
            chk("beat_valid", 64'(rsp_valid[d]), 64'd1);
            chk("beat_data", 64'(rsp_data[d]), 64'(base + 32'(i)));
            chk("beat_idx", 64'(rsp_beat[d]), 64'(i));
            chk("beat_last", 64'(rsp_last[d]), 64'(i == 15));
            if (hold) chk("busy_no_accept", 64'(req_ready[d]), 64'd0);
            if (i == rst_beat) begin
                rsp_ready[d] = 1'b0;
                rst_n[d]     = 1'b0;
                @(negedge clk);
                rst_n[d] = 1'b1;
                mreq[d]  = 0;
                mbeat[d] = 0;
                chk_idle(d, "mid_reset");
                return;
            end
            stalls = 0;
            if (mode == 1 && i == 7) stalls = 3;
            if (mode == 2) stalls = $urandom_range(0, 2);
            for (int j = 0; j < stalls; j++) begin
                rsp_ready[d] = 1'b0;
                @(negedge clk);
                chk("stall_valid", 64'(rsp_valid[d]), 64'd1);
                chk("stall_data", 64'(rsp_data[d]), 64'(base + 32'(i)));
                chk("stall_idx", 64'(rsp_beat[d]), 64'(i));
                chk("stall_last", 64'(rsp_last[d]), 64'(i == 15));
            end
            rsp_ready[d] = 1'b1;
            @(negedge clk);
            mbeat[d]++;
        end
        rsp_ready[d] = 1'b0;
        chk("done_req_ready", 64'(req_ready[d]), 64'd1);
        chk("done_rsp_valid", 64'(rsp_valid[d]), 64'd0);
        chk("done_busy", 64'(busy[d]), 64'd0);
        chk("done_req_count", 64'(req_count[d]), 64'(mreq[d]));
        chk("done_beat_count", 64'(beat_count[d]), 64'(mbeat[d]));
    endtask

    logic [31:0] stream [21];

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            req_addr[d]  = '0;
            mreq[d]      = 0;
            mbeat[d]     = 0;
        end
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        chk_idle(0, "reset4");
        chk_idle(1, "reset0");

        run_line(0, 32'h0000_1237, 0, -1, 1'b1, 32'h0000_2000);
        chk("basic_req_count", 64'(req_count[0]), 64'd1);
        chk("basic_beat_count", 64'(beat_count[0]), 64'd16);
        run_line(0, 32'h0000_2000, 0, -1, 1'b0, 32'h0);
        chk("busy_req_count", 64'(req_count[0]), 64'd2);

        run_line(0, 32'h0000_ABC0, 1, -1, 1'b0, 32'h0);
        chk("bp_beat_count", 64'(beat_count[0]), 64'd48);

        run_line(1, 32'hFFFF_FFF5, 0, -1, 1'b0, 32'h0);
        run_line(1, 32'h0000_0808, 2, -1, 1'b0, 32'h0);

        run_line(0, 32'h0000_1000, 0, 9, 1'b0, 32'h0);
        run_line(0, 32'h0000_0040, 0, -1, 1'b0, 32'h0);
        chk("post_reset_req_count", 64'(req_count[0]), 64'd1);

        pulse_reset(0);
        chk_idle(0, "pre_stream");
        for (int k = 0; k < 21; k++) stream[k] = $urandom;
        for (int k = 0; k < 20; k++) begin
            run_line(0, stream[k], 2, -1, k < 19, stream[k+1]);
        end
        chk("stream_req_count", 64'(req_count[0]), 64'd20);
        chk("stream_beat_count", 64'(beat_count[0]), 64'd320);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
